// File: rtl/sort_result_buffer.sv
// Captures one sorted frame into block RAM and checks its ordering.
// Reports count, first/last word, order violations and overflow.
module sort_result_buffer #(
  parameter int SIZE  = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             active_output,
  input  logic             clear,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             done,
  output logic             order_err,
  output logic             overflow,
  output logic [AW-1:0]    err_index,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] mem [SIZE];

  logic          full;
  logic          cap;
  logic [AW-1:0] waddr;

  assign full  = (count == (AW+1)'(SIZE));
  assign waddr = (state == IDLE) ? '0 : count[AW-1:0];

  always_comb begin
    state_n = state;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (active_output) begin
          cap     = 1'b1;
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (!active_output) begin
          state_n = DONE;
        end else if (!full) begin
          cap = 1'b1;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // clear wins over a word arriving the same cycle
    if (clear) begin
      state_n = IDLE;
      cap     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (cap && !rst) begin
      mem[waddr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  // max_val always holds the previously captured word
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count     <= '0;
      done      <= 1'b0;
      order_err <= 1'b0;
      overflow  <= 1'b0;
      err_index <= '0;
      min_val   <= '0;
      max_val   <= '0;
    end else begin
      if (state == COLLECT && !active_output) begin
        done <= 1'b1;
      end
      if (state == COLLECT && active_output && full) begin
        overflow <= 1'b1;
      end
      if (cap) begin
        count   <= count + 1'b1;
        max_val <= d;
        if (state == IDLE) begin
          min_val <= d;
        end else if (d < max_val && !order_err) begin
          order_err <= 1'b1;
          err_index <= waddr;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_result_buffer.sv
// Directed and random checks of sort_result_buffer against a
// queue-based frame model.
module tb_sort_result_buffer;

  localparam int SIZE  = 8;
  localparam int WIDTH = 16;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic             active_output;
  logic             clear;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      count;
  logic             done;
  logic             order_err;
  logic             overflow;
  logic [AW-1:0]    err_index;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;

  sort_result_buffer #(
    .SIZE (SIZE),
    .WIDTH(WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d            (d),
    .active_output(active_output),
    .clear        (clear),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .count        (count),
    .done         (done),
    .order_err    (order_err),
    .overflow     (overflow),
    .err_index    (err_index),
    .min_val      (min_val),
    .max_val      (max_val)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] q[$];
  bit               fin;
  bit               ovf;
  logic [WIDTH-1:0] mm [SIZE];
  bit               mv [SIZE];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    bit          oe;
    int unsigned ei;
    oe = 1'b0;
    ei = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (!oe && q[i] < q[i-1]) begin
        oe = 1'b1;
        ei = i;
      end
    end
    chk("count", 32'(count), 32'(q.size()));
    chk("done", 32'(done), 32'(fin));
    chk("order_err", 32'(order_err), 32'(oe));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("err_index", 32'(err_index), ei);
    chk("min_val", 32'(min_val), q.size() ? 32'(q[0]) : 0);
    chk("max_val", 32'(max_val), q.size() ? 32'(q[$]) : 0);
  endtask

  task automatic cyc(input bit r, input bit c, input bit a,
                     input logic [WIDTH-1:0] dd,
                     input logic [AW-1:0] ra);
    bit               known;
    logic [WIDTH-1:0] exp_rd;
    rst           = r;
    clear         = c;
    active_output = a;
    d             = dd;
    rd_addr       = ra;
    known  = r || mv[ra];
    exp_rd = r ? '0 : mm[ra];
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      fin = 1'b0;
      ovf = 1'b0;
      foreach (mv[i]) mv[i] = 1'b0;
    end else if (c) begin
      q.delete();
      fin = 1'b0;
      ovf = 1'b0;
    end else if (!fin) begin
      if (a) begin
        if (q.size() < SIZE) begin
          mm[q.size()] = dd;
          mv[q.size()] = 1'b1;
          q.push_back(dd);
        end else begin
          ovf = 1'b1;
        end
      end else if (q.size() > 0) begin
        fin = 1'b1;
      end
    end
    if (known) chk("rd_data", 32'(rd_data), 32'(exp_rd));
    check_state();
  endtask

  task automatic feed(input logic [WIDTH-1:0] w);
    cyc(0, 0, 1, w, 3'(q.size()));
  endtask

  task automatic gap();
    cyc(0, 0, 0, '0, '0);
  endtask

  initial begin
    logic [WIDTH-1:0] f1 [8];
    logic [WIDTH-1:0] f2 [5];
    logic [WIDTH-1:0] last;
    f1 = '{1, 3, 3, 5, 7, 9, 11, 12};
    f2 = '{2, 4, 1, 6, 0};
    fin = 1'b0;
    ovf = 1'b0;
    foreach (mv[i]) mv[i] = 1'b0;

    cyc(1, 0, 0, '0, '0);
    cyc(1, 1, 1, 16'h55, '0);
    gap();

    foreach (f1[i]) feed(f1[i]);
    gap();
    chk("frame1_done", 32'(done), 1);
    cyc(0, 0, 1, 16'h99, '0);
    for (int i = 0; i < SIZE; i++) cyc(0, 0, 0, '0, 3'(i));

    cyc(0, 1, 0, '0, '0);
    foreach (f2[i]) feed(f2[i]);
    gap();
    chk("frame2_err_index", 32'(err_index), 2);

    cyc(0, 1, 0, '0, '0);
    for (int i = 0; i < 10; i++) feed(WIDTH'(10 * i + 3));
    gap();
    chk("frame3_overflow", 32'(overflow), 1);
    for (int i = 0; i < SIZE; i++) cyc(0, 0, 0, '0, 3'(i));

    cyc(0, 1, 1, 16'd5, '0);
    chk("clear_count", 32'(count), 0);
    cyc(0, 0, 1, 16'd7, '0);
    feed(16'd8);
    gap();

    cyc(0, 1, 0, '0, '0);
    feed(16'd4);
    feed(16'd5);
    feed(16'd6);
    cyc(1, 0, 1, 16'd9, '0);
    chk("rst_count", 32'(count), 0);
    for (int i = 0; i < 4; i++) feed(WIDTH'(20 + i));
    gap();
    chk("frame5_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0, 3'(i));

    last = '0;
    for (int n = 0; n < 600; n++) begin
      bit               r;
      bit               c;
      bit               a;
      logic [WIDTH-1:0] w;
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 4) || (fin && $urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 9) == 0) w = WIDTH'($urandom);
      else w = last + WIDTH'($urandom_range(0, 3));
      last = w;
      if (c) last = WIDTH'($urandom_range(0, 50));
      cyc(r, c, a, w, AW'($urandom_range(0, SIZE - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sort_result_buffer.md
SORT_RESULT_BUFFER -- requirements
Module: sort_result_buffer

Interface
REQ-001 The block SHALL have parameter SIZE, default 1024, meaning the maximum number of words per sorted frame.
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the data word width in bits.
REQ-003 The block SHALL have derived parameter AW, default $clog2(SIZE), meaning the address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port d, input, WIDTH bits: sorted word from the upstream sorter q output.
REQ-007 The block SHALL have port active_output, input, 1 bit: high while d carries a valid sorted word, one word per cycle.
REQ-008 The block SHALL have port clear, input, 1 bit: single-cycle pulse that re-arms the block for the next frame.
REQ-009 The block SHALL have port rd_addr, input, AW bits: read address into the captured frame.
REQ-010 The block SHALL have port rd_data, output, WIDTH bits: registered read data.
REQ-011 The block SHALL have port count, output, AW+1 bits: number of words captured.
REQ-012 The block SHALL have ports done, order_err and overflow, outputs, 1 bit each: frame complete, order violation, excess words.
REQ-013 The block SHALL have ports err_index (AW bits), min_val and max_val (WIDTH bits), outputs: first violation index, first word, last word.

Function
REQ-014 The block SHALL implement a three-state machine: IDLE, COLLECT, DONE.
REQ-015 IDLE: a cycle with active_output=1 SHALL write d at index 0, set count=1, latch min_val=d and max_val=d, and go to COLLECT.
REQ-016 COLLECT: each cycle with active_output=1 and count<SIZE SHALL write d at index count, increment count and update max_val=d.
REQ-017 COLLECT: the first cycle with active_output=0 SHALL go to DONE and set done=1 on the next edge; any gap ends the frame.
REQ-018 COLLECT: a cycle with active_output=1 and count==SIZE SHALL drop d, set overflow=1 (sticky) and leave count, memory and max_val unchanged.
REQ-019 The order check SHALL compare each captured word after index 0 unsigned against the previously captured word.
REQ-020 On the first word less than its predecessor, the block SHALL set order_err=1 (sticky) and err_index to that word's index; later violations SHALL NOT change err_index.
REQ-021 Equal adjacent words SHALL NOT be flagged.
REQ-022 DONE SHALL ignore active_output and hold count, flags, min_val and max_val.
REQ-023 clear=1 SHALL, in any state, go to IDLE and zero count, done, order_err, overflow, err_index, min_val and max_val on the next edge.
REQ-024 clear SHALL take priority over a simultaneous active_output=1, and that word SHALL NOT be captured.
REQ-025 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is presented, in every state.
REQ-026 A read and a write to the same address in the same cycle SHALL return the old contents.
REQ-027 Addresses >= count SHALL return unspecified stale data.
REQ-028 Memory SHALL be SIZE x WIDTH and inferable as block RAM: one write port, one synchronous read port, no reset.

Reset
REQ-029 rst=1 SHALL force IDLE and zero rd_data, count, done, order_err, overflow, err_index, min_val and max_val on the next edge.
REQ-030 rst SHALL take priority over clear and active_output.
REQ-031 rst asserted mid-COLLECT SHALL abort the frame; memory contents SHALL be left undefined.

Verification
REQ-032 SIZE=8 bench: feed 1,3,3,5,7,9,11,12 with active_output high for 8 cycles, then low -> done=1, count=8, order_err=0, overflow=0, min_val=1, max_val=12; rd_addr 0..7 return the same sequence with 1-cycle latency.
REQ-033 SIZE=8 bench: feed 2,4,1,6,0 then drop active_output -> count=5, order_err=1, err_index=2, max_val=0.
REQ-034 SIZE=8 bench: feed 10 ascending words -> count=8, overflow=1, max_val=8th word; words 9 and 10 are not stored.
REQ-035 SIZE=8 bench: in DONE, pulse clear in the same cycle active_output rises with d=5 -> next cycle IDLE, all flags 0, count=0; the following word starts a new frame at index 0.
REQ-036 SIZE=8 bench: assert rst after 3 captured words -> next cycle count=0, done=0, IDLE; a new 4-word frame then completes with count=4.
REQ-037 Full bench: connect the upstream sorter (SIZE=1024, WIDTH=32) fed with random data -> done=1, count=1024, order_err=0, overflow=0.
